// File: rtl/sel_decoder_timed.sv
// Registered one-hot select decoder with load strobe, hold/timed-pulse modes,
// out-of-range code detection and busy/done status. All outputs come from flops.
module sel_decoder_timed #(
    parameter int W         = 3,
    parameter int NOUT      = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            en_i,
    input  logic            stb_i,
    input  logic [W-1:0]    code_i,
    input  logic            mode_i,
    output logic [NOUT-1:0] y_o,
    output logic            busy_o,
    output logic            err_o,
    output logic            done_o
);

    localparam int CNTW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NOUT-1:0]   y_q, y_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              codeValid;
    logic [NOUT-1:0]   codeOneHot;

    // Compare at W+1 bits so that NOUT == 2^W never flags an error.
    always_comb begin
        codeValid  = ({1'b0, code_i} < (W+1)'(NOUT));
        codeOneHot = '0;
        for (int i = 0; i < NOUT; i++) begin
            codeOneHot[i] = ({1'b0, code_i} == (W+1)'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        done_d  = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if (stb_i) begin
                        if (codeValid) begin
                            y_d = codeOneHot;
                            if (mode_i) begin
                                state_d = PULSE;
                                cnt_d   = CNTW'(PULSE_LEN - 1);
                                busy_d  = 1'b1;
                            end else begin
                                state_d = HOLD;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                // Strobes are deliberately ignored for the whole pulse.
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        y_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    y_d     = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign y_o    = y_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;
    assign done_o = done_q;

endmodule

// File: doc/sel_decoder_timed.md
# sel_decoder_timed

Registered, parametrised one-hot select decoder with a load strobe and a timed-pulse mode. A W-bit code is captured on a strobe and drives one of NOUT select lines, either held until the next strobe or asserted for a fixed PULSE_LEN cycles. It sits between the vending-machine control FSM and the item-release and display-enable lines. It adds out-of-range code detection plus busy and done status.

## Interface
Parameters:
- W, 3, code width in bits (1..8).
- NOUT, 8, number of select outputs, 1..2^W. Codes >= NOUT are invalid.
- PULSE_LEN, 4, cycles Y stays high in pulse mode (>= 1).

Ports:
- Clock  in  1  rising-edge clock. One clock only.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  global enable. Low forces a clear on the next edge.
- STB  in  1  load request, sampled on the rising edge of Clock.
- CODE  in  W  select code, sampled with STB.
- MODE  in  1  sampled with STB. 0 = hold (level), 1 = timed pulse.
- Y  out  NOUT  registered one-hot select; Y[i] high selects output i.
- BUSY  out  1  registered; high while a timed pulse is in progress.
- ERR  out  1  registered single-cycle pulse when an accepted STB carried CODE >= NOUT.
- DONE  out  1  registered single-cycle pulse when a timed pulse ends naturally.

## Operation
- States: IDLE, PULSE, HOLD. Down-counter CNT, width clog2(PULSE_LEN+1).
- Reset, and every reset cycle: state IDLE, Y=0, BUSY=0, ERR=0, DONE=0, CNT=0.
- EN=0 has priority over STB in every state. Next edge: Y=0, BUSY=0, state IDLE, no DONE, no ERR.
- ERR and DONE are low in every cycle unless set by the rules below.
- IDLE, STB=1, CODE<NOUT:
  - Y <= one-hot(CODE).
  - MODE=1: go to PULSE, CNT <= PULSE_LEN-1, BUSY <= 1.
  - MODE=0: go to HOLD.
- IDLE, STB=1, CODE>=NOUT: ERR <= 1, Y stays 0, stay IDLE.
- PULSE:
  - STB is ignored entirely: no ERR, no retarget.
  - CNT!=0: CNT <= CNT-1.
  - CNT==0: Y <= 0, BUSY <= 0, DONE <= 1, go to IDLE.
- HOLD, STB=1, CODE<NOUT: Y <= one-hot(CODE) with no zero gap. MODE=1 enters PULSE exactly as from IDLE.
- HOLD, STB=1, CODE>=NOUT: ERR <= 1, Y unchanged, stay HOLD.
- HOLD, STB=0: Y unchanged indefinitely.
- Invariant: Y is zero or exactly one-hot. Y[i] for i>=NOUT does not exist.
- Width rule: the CODE comparison against NOUT is unsigned at width W+1, so NOUT=2^W never flags an error.

## Timing
- Load latency: STB sampled at edge k means Y, BUSY, and ERR take their new value after edge k.
- Pulse mode: Y is high for exactly PULSE_LEN cycles. BUSY is coincident with Y.
- DONE is high in the first cycle Y is low again.
- PULSE_LEN=1: Y high for one cycle, then DONE in the next cycle.
- STB in the cycle DONE is high is accepted, because the state is already IDLE. Minimum pulse-to-pulse spacing is PULSE_LEN+1 cycles.
- STB in the last PULSE cycle (CNT==0) is dropped.
- Reset or EN=0 mid-pulse: Y is cleared at the next edge with no DONE. A STB in the same cycle is ignored.
- Reset and EN=0 both override STB.
- All outputs are driven directly from flops, with no combinational path from input to output.

## Test plan
All scenarios use W=3, NOUT=6, PULSE_LEN=4.
- Reset is held for 2 cycles, then released -> Y=6'b000000, BUSY=0, ERR=0, DONE=0.
- STB=1, CODE=2, MODE=0 for one cycle -> Y=6'b000100 from the next cycle and held for 20 idle cycles. Then STB with CODE=5 -> Y=6'b100000 with no zero cycle between.
- STB with CODE=3, MODE=1 ->
  - Y=6'b001000 and BUSY=1 for exactly 4 cycles.
  - Then Y=0 and DONE=1 for 1 cycle.
  - STB with CODE=1 on cycles 2 and 4 of the pulse are ignored: no ERR, Y unchanged.
- STB with CODE=7 in IDLE -> ERR=1 for 1 cycle, Y=0. Then STB with CODE=6 in HOLD on code 0 -> ERR=1, Y stays 6'b000001.
- Pulse started with CODE=4. EN=0 in pulse cycle 2 -> Y=0 and BUSY=0 next cycle, DONE never asserted. Repeat with Reset instead of EN=0 -> same result.
- Pulse with CODE=0. STB with CODE=1, MODE=1 in the DONE cycle -> new pulse Y=6'b000010 starts the next cycle, lasts 4 cycles, and ends with DONE.
